// File: rtl/quad_counter_pkg.sv
// ============================================================================
// quad_counter_pkg : shared types, constants and Gray step decode for the
//                    quadrature encoder channel front end.
// Revision: 1.0
// ============================================================================
`default_nettype none

package quad_counter_pkg;

  localparam int FC_W       = 3;
  localparam int DEF_FILTER = 4;
  localparam bit DEF_FULL   = 1'b0;
  localparam int DEF_CW     = 10;

  typedef struct packed {
    logic illegal;
    logic dir;      // 1 = count up
    logic step;
  } step_t;

  // Gray phase 00,01,11,10 maps to ordinal 0,1,2,3; the ordinal delta
  // between samples gives direction, and a delta of two is a lost phase.
  function automatic step_t gray_step(input logic [1:0] p, input logic [1:0] f);
    logic [1:0] w_pi;
    logic [1:0] w_fi;
    logic [1:0] w_d;
    step_t      w_r;
    w_pi = {p[1], p[1] ^ p[0]};
    w_fi = {f[1], f[1] ^ f[0]};
    w_d  = w_fi - w_pi;
    w_r  = '0;
    case (w_d)
      2'd1:    begin w_r.step = 1'b1; w_r.dir = 1'b1; end
      2'd3:    begin w_r.step = 1'b1; w_r.dir = 1'b0; end
      2'd2:    w_r.illegal = 1'b1;
      default: w_r = '0;
    endcase
    return w_r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_counter_noise_filter.sv
// ============================================================================
// noise_filter : two-flop synchronizer followed by a consecutive-sample
//                stability filter on one quadrature phase pair.
// Revision: 1.0
// ============================================================================
`default_nettype none

module noise_filter
  import quad_counter_pkg::*;
#(
  parameter int FILTER = DEF_FILTER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic [1:0] out
);

  logic [1:0] r_s1;
  logic [1:0] r_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 2'b00;
      r_s2 <= 2'b00;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
    end
  end

  generate
    if (FILTER > 1) begin : g_filter
      localparam logic [FC_W-1:0] C_LAST = FC_W'(FILTER - 1);
      localparam logic [FC_W-1:0] C_ONE  = FC_W'(1);

      logic [1:0]      r_s3;
      logic [1:0]      r_f;
      logic [FC_W-1:0] r_fc;
      logic            w_differs;
      logic            w_moved;

      assign w_differs = (r_s2 != r_f);
      // A new candidate value restarts the stability count.
      assign w_moved   = (r_s2 != r_s3) && (r_fc != '0);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s3 <= 2'b00;
          r_f  <= 2'b00;
          r_fc <= '0;
        end else begin
          r_s3 <= r_s2;
          if (!w_differs || w_moved) begin
            r_fc <= '0;
          end else if (r_fc == C_LAST) begin
            r_f  <= r_s2;
            r_fc <= '0;
          end else if (r_fc != '1) begin
            r_fc <= r_fc + C_ONE;
          end
        end
      end

      assign out = r_f;
    end else begin : g_bypass
      logic [1:0] r_f;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_f <= 2'b00;
        end else begin
          r_f <= r_s2;
        end
      end

      assign out = r_f;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/quad_counter.sv
// ============================================================================
// quad_counter : one encoder channel - filtered phase input, Gray decode,
//                wrapping up/down position count and sticky error flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module quad_counter
  import quad_counter_pkg::*;
#(
  parameter int FILTER = DEF_FILTER,
  parameter bit FULL   = DEF_FULL,
  parameter int CW     = DEF_CW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] q,
  input  logic       clr,
  output logic [7:0] count,
  output logic       err
);

  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [1:0]    w_f;
  logic [1:0]    r_p;
  logic [CW-1:0] r_pos;
  logic [CW-1:0] w_pos_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic [7:0]    r_count;
  logic [7:0]    w_count_nxt;
  step_t         w_step;

  noise_filter #(
    .FILTER (FILTER)
  ) u_filter (
    .clk (clk),
    .rst (rst),
    .in  (q),
    .out (w_f)
  );

  assign w_step = gray_step(r_p, w_f);

  // clr wins over any decode result in the same cycle.
  always_comb begin
    w_pos_nxt = r_pos;
    w_err_nxt = r_err;
    if (clr) begin
      w_pos_nxt = '0;
      w_err_nxt = 1'b0;
    end else if (w_step.illegal) begin
      w_err_nxt = 1'b1;
    end else if (w_step.step) begin
      w_pos_nxt = w_step.dir ? (r_pos + C_ONE) : (r_pos - C_ONE);
    end
  end

  generate
    if (FULL) begin : g_full
      assign w_count_nxt = w_pos_nxt[7:0];
    end else begin : g_coarse
      assign w_count_nxt = w_pos_nxt[9:2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p     <= 2'b00;
      r_pos   <= '0;
      r_err   <= 1'b0;
      r_count <= 8'h00;
    end else begin
      r_p     <= w_f;
      r_pos   <= w_pos_nxt;
      r_err   <= w_err_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign count = r_count;
  assign err   = r_err;

endmodule

`default_nettype wire

// File: doc/quad_counter.md
Name: quad_counter

Overview:
- Per-channel front end of the encoder counter: synchronizes one quadrature input pair, applies a noise filter and decodes Gray transitions.
- Maintains an up/down position count and presents it as the 8-bit value the bus read logic returns.
- Instantiated once per encoder channel, directly upstream of the bus multiplexer.
- Per-channel filter size and resolution mode are set by parameters.

Parameters:
- FILTER, 4, consecutive stable samples required before a new phase value is accepted; 1 = no filter; legal range 1..7.
- FULL, 0, 1 = output count[7:0] (full quadrature resolution); 0 = output count[9:2] (one step per encoder period).
- CW, 10, internal counter width; must be at least 10.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- q  input  2  raw encoder phases {A,B}, asynchronous to clk.
- clr  input  1  synchronous clear of count and err, active high.
- count  output  8  position value (see FULL).
- err  output  1  sticky illegal-transition flag.

Behaviour:
- Reset (rst=0, asynchronous): sync stages, filtered phase, previous phase and filter counter all go to 00/0; internal count=0; count=0; err=0.
- Synchronizer: two flops on q; s2 is the synchronized value.
- Filter, FILTER>1:
  - A saturating counter fc (3 bits) counts consecutive cycles where s2 != filtered phase f.
  - fc clears whenever s2 == f, or whenever s2 changes value while fc is running.
  - When fc reaches FILTER-1 and s2 still differs, f <= s2 and fc <= 0.
- Filter, FILTER=1: f <= s2 every cycle.
- Latency: a q change first sampled at edge N appears in f at edge N+FILTER+1 and in count at edge N+FILTER+2.
- Glitches shorter than FILTER cycles never reach f.
- Decoder: p holds the previous f, registered every cycle.
  - Forward sequence 00->01->11->10->00: +1.
  - Reverse sequence: -1.
  - f == p: no change.
  - Double step (00<->11, 01<->10): count unchanged, err <= 1.
- Count arithmetic: CW-bit two's complement, wraps modulo 2^CW with no saturation.
  - Example: 0 minus 1 = all ones, so count = 8'hFF in both modes.
- Output is registered, equal to internal count[7:0] if FULL, else count[9:2]. It updates in the same cycle as the internal count.
- clr priority: clr=1 forces internal count=0 and err=0 at the next edge, overriding any simultaneous decode step and any simultaneous illegal transition.
  - The filter and p are not cleared, so no spurious step occurs after clr.
- err stays set until clr or reset.
- Reset mid-operation: all state is lost.
  - After rst deasserts, if q is not 00, the filter accepts the current q after the normal latency.
  - This produces one decoded step (or err, for 11) relative to 00; software clears it.

Decomposition:
- Shared package/include holds:
  - Gray step decode function, taking (p, f) and returning {illegal, dir, step};
  - filter counter width constant (3);
  - default FILTER/FULL values used by the top-level instantiation.
- One sub-module, noise_filter (parameter FILTER; ports clk, rst, in[1:0], out[1:0]), containing the synchronizer and filter.
- The decoder and counter stay in quad_counter.

Test Plan:
- FILTER=1, FULL=1: after reset drive q 00->01->11->10->00, each held 8 cycles -> count 1,2,3,4, each appearing 3 edges after the q change; err=0.
- FILTER=4, FULL=0: 40 forward steps, 10 cycles each -> count=10 (40>>2); then 3 reverse steps -> internal 37, count=9.
- FILTER=4: from 00, pulse q=01 for 3 cycles then back to 00 -> count unchanged and f never changes. A 4-cycle pulse -> +1 then -1; count ends 0.
- Illegal transition: q 00->11 held 10 cycles -> count unchanged, err=1. Assert clr for 1 cycle -> err=0, count=0. Then 11->10 -> count=1.
- Wrap: from reset, one reverse step with FULL=1 -> count=8'hFF. With FULL=0, 4 reverse steps -> count=8'hFF.
- Reset mid-operation: count=5, assert rst while q=01, release -> count=0 immediately, then count=1 at FILTER+2 edges after the first sampling edge.
